keyed_mix_pipe: RTL and testbench
=================================

// Module: keyed_mix_pipe
// PURPOSE
//  Multi-lane, pipelined, runtime-moded successor of the bitwise invert/XOR-shift transform block.
//  Accepts one WIDTH-bit word per cycle over a valid/ready stream, each tagged with a lane ID.
//  Applies a per-lane keyed transform and delivers the result STAGES cycles later with full backpressure.
//  Sits between an upstream producer and a downstream consumer in the datapath; per-lane keys are software-programmed.
// PARAMETERS
//  WIDTH   32  data word width, >= 2
//  LANES   4   number of lanes, each with its own key register, >= 1
//  STAGES  2   pipeline depth = latency in cycles, >= 1
//  CNT_W   16  per-lane statistics counter width (only used with KEYED_MIX_STATS_EN)
//  LANE_W  derived: (LANES>1) ? $clog2(LANES) : 1
// PORTS
//  clk        in   1       clock; all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       input word valid
//  in_ready   out  1       input accepted when in_valid && in_ready
//  in_data    in   WIDTH   input word
//  in_lane    in   LANE_W  lane tag; values >= LANES are treated as lane 0
//  in_mode    in   2       transform select, see BEHAVIOUR
//  out_valid  out  1       output word valid
//  out_ready  in   1       downstream accept
//  out_data   out  WIDTH   transformed word
//  out_lane   out  LANE_W  lane tag carried with the word
//  cfg_we     in   1       key write strobe
//  cfg_lane   in   LANE_W  key write target; writes to lanes >= LANES are ignored
//  cfg_key    in   WIDTH   key write data
// BEHAVIOUR
//  - Modes (k = key[lane], x = in_data):
//    00 PASS = x; 01 INV = ~x; 10 KEYED = ~x ^ k; 11 KEYED_ROT = rotl(~x ^ k, 1).
//  - Transform is computed combinationally into stage 1.
//    Stages 2..STAGES are pure delay registers carrying {valid, data, lane}.
//  - advance = !out_valid || out_ready. in_ready = advance.
//    All stages shift together only when advance is high; otherwise every stage holds.
//  - out_* are driven directly from the last stage. Latency is exactly STAGES cycles when out_ready stays high.
//    Throughput is 1 word/cycle. Bubbles are not squeezed.
//  - out_data and out_lane stay stable while out_valid && !out_ready.
//  - Key write takes effect the cycle after cfg_we.
//    A word accepted in the same cycle as a write to its lane uses the old key.
//  - Reset: every stage valid=0, data=0, lane=0; out_valid=0, out_data=0, out_lane=0.
//    Every key = WIDTH/2 (32 -> 0x10). in_ready=1 in the first cycle after reset.
//  - Reset mid-operation discards all in-flight words. No output handshake completes in the reset cycle.
//  - A stalled pipeline does not block cfg writes.
// CONFIGURATION
//  - KEYED_MIX_STATS_EN defined:
//    - Adds ports stat_lane (in, LANE_W), stat_clr (in, 1) and stat_count (out, CNT_W).
//    - Adds one CNT_W counter per lane, incremented on each out_valid && out_ready for out_lane.
//      Each counter saturates at all-ones.
//    - stat_clr zeroes all counters; clear wins over a simultaneous increment.
//    - stat_count = counter[stat_lane], registered, 1-cycle read latency. Reads 0 for stat_lane >= LANES.
//    - Counters reset to 0.
//  - KEYED_MIX_STATS_EN undefined: these ports and counters do not exist; datapath behaviour is identical.
// STRUCTURE
//  - keyed_mix_pkg:
//    - mode_e enum {MODE_PASS, MODE_INV, MODE_KEYED, MODE_KEYED_ROT}
//    - function rotl1(), function mix(x, k, mode)
//    - localparam KEY_RST_DIV = 2
//  - Sub-module keyed_mix_stage:
//    - One register stage holding {valid, data, lane}, with enable and sync reset.
//    - Instantiated STAGES times in a generate loop.
//  - Key bank, mode decode and stats counters live in the top module.
// TESTING (WIDTH=32, LANES=4, STAGES=2)
//  1. PASS, in_data=0x1234_5678, lane 2, out_ready=1
//     -> out_data=0x1234_5678, out_lane=2, out_valid exactly 2 cycles after accept.
//  2. INV 0x0000_00FF -> 0xFFFF_FF00.
//     KEYED lane 0, reset key, in 0 -> 0xFFFF_FFEF.
//     KEYED_ROT same input -> 0xFFFF_FFDF.
//  3. Write key 0xA5A5_A5A5 to lane 1 while sending KEYED 0 on lane 1 in the same cycle
//     -> first out 0xFFFF_FFEF.
//     Next word 0 on lane 1 -> 0x5A5A_5A5A.
//  4. Back-to-back 8 words with out_ready low for 3 cycles mid-stream
//     -> in_ready low during stall, no loss or duplication, order kept, out_data stable while stalled.
//  5. Assert rst with 2 words in flight -> out_valid=0 next cycle.
//     Keys back to 0x10. Those 2 words are never emitted.
//  6. [KEYED_MIX_STATS_EN] 5 words on lane 3, then stat_lane=3 -> stat_count=5.
//     stat_clr together with a lane-3 output handshake -> 0.
//     With CNT_W=2: 5 words -> 3 (saturated).

Source files
------------

// File: rtl/keyed_mix_pkg.sv
// keyed_mix_pkg
//   Shared types and transform helpers for keyed_mix_pipe.
//   - mode_e      : 2-bit transform select
//   - rotl1()     : rotate-left by one within a runtime width
//   - mix()       : the per-word keyed transform
//   - KEY_RST_DIV : key reset value is WIDTH / KEY_RST_DIV
//   Helpers work on a wide container word so one function serves any
//   WIDTH up to MIX_MAX_W; callers cast the result back to their width.
package keyed_mix_pkg;

    localparam int KEY_RST_DIV = 2;
    localparam int MIX_MAX_W   = 128;

    typedef logic [MIX_MAX_W-1:0] mix_word_t;

    typedef enum logic [1:0] {
        MODE_PASS      = 2'b00,
        MODE_INV       = 2'b01,
        MODE_KEYED     = 2'b10,
        MODE_KEYED_ROT = 2'b11
    } mode_e;

    function automatic mix_word_t width_mask(input int w);
        return (w >= MIX_MAX_W) ? '1 : ((mix_word_t'(1) << w) - mix_word_t'(1));
    endfunction

    // v must already be confined to its low w bits.
    function automatic mix_word_t rotl1(input mix_word_t v, input int w);
        return ((v << 1) | (v >> (w - 1))) & width_mask(w);
    endfunction

    function automatic mix_word_t mix(input mix_word_t x, input mix_word_t k,
                                      input mode_e mode, input int w);
        mix_word_t t;
        t = (~x ^ k) & width_mask(w);
        case (mode)
            MODE_PASS:  return x & width_mask(w);
            MODE_INV:   return ~x & width_mask(w);
            MODE_KEYED: return t;
            default:    return rotl1(t, w);
        endcase
    endfunction

endpackage

// File: rtl/keyed_mix_pipe_stage.sv
// keyed_mix_stage
//   One pipeline register holding {valid, data, lane}.
//   Ports: clk, rst (sync, active-high), en (load enable),
//          in_valid/in_data/in_lane -> out_valid/out_data/out_lane.
module keyed_mix_stage #(
    parameter int WIDTH  = 32,
    parameter int LANE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [LANE_W-1:0] in_lane,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [LANE_W-1:0] out_lane
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= in_data;
            out_lane  <= in_lane;
        end
    end

endmodule

// File: rtl/keyed_mix_pipe.sv
// keyed_mix_pipe
//   Multi-lane pipelined keyed transform with valid/ready on both sides.
//   The transform is computed combinationally into stage 1; further stages
//   are plain delay. The whole pipe advances as one when the output slot is
//   empty or being drained, so latency is STAGES cycles with no stalls.
//   Ports:
//     clk, rst                      clock, sync active-high reset
//     in_valid/in_ready/in_data/in_lane/in_mode   input stream
//     out_valid/out_ready/out_data/out_lane       output stream
//     cfg_we/cfg_lane/cfg_key       per-lane key write
//     stat_lane/stat_clr/stat_count per-lane output counters
//                                   (only with KEYED_MIX_STATS_EN defined)
//   Optional feature macro: KEYED_MIX_STATS_EN
module keyed_mix_pipe
    import keyed_mix_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16,
    parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [LANE_W-1:0] in_lane,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [LANE_W-1:0] out_lane,
    input  logic              cfg_we,
    input  logic [LANE_W-1:0] cfg_lane,
    input  logic [WIDTH-1:0]  cfg_key
`ifdef KEYED_MIX_STATS_EN
    ,
    input  logic [LANE_W-1:0] stat_lane,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stat_count
`endif
);

    // One extra bit so LANES itself is representable for range checks.
    localparam logic [LANE_W:0]   LANES_L = (LANE_W + 1)'(LANES);
    localparam logic [WIDTH-1:0]  KEY_RST = WIDTH'(WIDTH / KEY_RST_DIV);

    logic                         advance;
    logic [LANES-1:0][WIDTH-1:0]  keys;
    logic [LANE_W-1:0]            lane_eff;
    logic [WIDTH-1:0]             key_sel;

    // Index 0 is the combinational stage-1 input; index STAGES is the output.
    logic [STAGES:0]              vld_pipe;
    logic [STAGES:0][WIDTH-1:0]   data_pipe;
    logic [STAGES:0][LANE_W-1:0]  lane_pipe;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Out-of-range lane tags fold onto lane 0 for both key and tag.
    assign lane_eff = ({1'b0, in_lane} < LANES_L) ? in_lane : '0;
    assign key_sel  = keys[lane_eff];

    // Key bank; independent of pipeline stalls. A same-cycle write is seen
    // only by later words because key_sel reads the registered value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) keys[i] <= KEY_RST;
        end else if (cfg_we && ({1'b0, cfg_lane} < LANES_L)) begin
            keys[cfg_lane] <= cfg_key;
        end
    end

    assign vld_pipe[0]  = in_valid;
    assign data_pipe[0] = WIDTH'(mix(mix_word_t'(in_data), mix_word_t'(key_sel),
                                     mode_e'(in_mode), WIDTH));
    assign lane_pipe[0] = lane_eff;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        keyed_mix_stage #(
            .WIDTH  (WIDTH),
            .LANE_W (LANE_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (advance),
            .in_valid  (vld_pipe[s]),
            .in_data   (data_pipe[s]),
            .in_lane   (lane_pipe[s]),
            .out_valid (vld_pipe[s+1]),
            .out_data  (data_pipe[s+1]),
            .out_lane  (lane_pipe[s+1])
        );
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_data  = data_pipe[STAGES];
    assign out_lane  = lane_pipe[STAGES];

`ifdef KEYED_MIX_STATS_EN
    logic [LANES-1:0][CNT_W-1:0] cnt;
    logic                        out_hs;

    assign out_hs = out_valid && out_ready;

    // Clear takes priority over a same-cycle increment; counts saturate.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            cnt <= '0;
        end else if (out_hs && ({1'b0, out_lane} < LANES_L) && (cnt[out_lane] != '1)) begin
            cnt[out_lane] <= cnt[out_lane] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_count <= '0;
        end else begin
            stat_count <= ({1'b0, stat_lane} < LANES_L) ? cnt[stat_lane] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_keyed_mix_pipe.sv
// tb_keyed_mix_pipe
//   Self-checking bench for keyed_mix_pipe (WIDTH=32, LANES=4, STAGES=2).
//   A transaction-level model (expected-word queue + key array) predicts
//   every output handshake; directed sequences cover latency, key update
//   ordering, stalls and mid-flight reset, followed by a random phase.
//   Define KEYED_MIX_STATS_EN to include the statistics ports and checks.
module tb_keyed_mix_pipe;

    localparam int WIDTH  = 32;
    localparam int LANES  = 4;
    localparam int STAGES = 2;
    localparam int CNT_W  = 16;
    localparam int LANE_W = 2;
    localparam longint CMAX = (64'd1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data = '0;
    logic [LANE_W-1:0] in_lane = '0;
    logic [1:0]        in_mode = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  out_data;
    logic [LANE_W-1:0] out_lane;
    logic              cfg_we = 1'b0;
    logic [LANE_W-1:0] cfg_lane = '0;
    logic [WIDTH-1:0]  cfg_key = '0;
`ifdef KEYED_MIX_STATS_EN
    logic [LANE_W-1:0] stat_lane = '0;
    logic              stat_clr = 1'b0;
    logic [CNT_W-1:0]  stat_count;
`endif

    always #5 clk = ~clk;

    keyed_mix_pipe #(
        .WIDTH  (WIDTH),
        .LANES  (LANES),
        .STAGES (STAGES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_lane   (in_lane),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .cfg_we    (cfg_we),
        .cfg_lane  (cfg_lane),
        .cfg_key   (cfg_key)
`ifdef KEYED_MIX_STATS_EN
        ,
        .stat_lane  (stat_lane),
        .stat_clr   (stat_clr),
        .stat_count (stat_count)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0]  d;
        logic [LANE_W-1:0] l;
    } exp_t;

    exp_t             q[$];
    logic [WIDTH-1:0] keys_m[LANES];
    int               n_chk  = 0;
    int               n_pass = 0;
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic [LANE_W-1:0] prev_lane;
    bit               acc, ohs;
    logic [WIDTH-1:0] last_out;
`ifdef KEYED_MIX_STATS_EN
    longint           cnt_m[LANES];
    longint           stat_exp = 0;
    bit               stat_exp_vld = 1'b0;
    logic [LANE_W-1:0] stat_lane_n = '0;
    bit               stat_clr_n = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [WIDTH-1:0] mix_m(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] k,
                                              input logic [1:0] m);
        logic [WIDTH-1:0] t;
        t = ~x ^ k;
        case (m)
            2'd0:    return x;
            2'd1:    return ~x;
            2'd2:    return t;
            default: return {t[WIDTH-2:0], t[WIDTH-1]};
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < LANES; i++) keys_m[i] = 32'h10;
        prev_stall = 1'b0;
`ifdef KEYED_MIX_STATS_EN
        for (int i = 0; i < LANES; i++) cnt_m[i] = 0;
        stat_exp = 0;
        stat_exp_vld = 1'b1;
`endif
    endtask

    // One clock: drive at negedge, observe 1ns later, update the model.
    task automatic step(input bit v, input logic [WIDTH-1:0] d, input logic [LANE_W-1:0] ln,
                        input logic [1:0] md, input bit ordy, input bit we,
                        input logic [LANE_W-1:0] cl, input logic [WIDTH-1:0] ck, input bit r);
        exp_t e;
        @(negedge clk);
        in_valid = v; in_data = d; in_lane = ln; in_mode = md; out_ready = ordy;
        cfg_we = we; cfg_lane = cl; cfg_key = ck; rst = r;
`ifdef KEYED_MIX_STATS_EN
        stat_lane = stat_lane_n; stat_clr = stat_clr_n;
`endif
        #1;
        if (r) begin
            model_reset();
            return;
        end
        acc = v && in_ready;
        ohs = out_valid && ordy;
        chk("in_ready", 64'(in_ready), 64'(!out_valid || ordy));
        if (prev_stall) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", 64'(out_data), 64'(prev_data));
            chk("stall_lane", 64'(out_lane), 64'(prev_lane));
        end
        if (ohs) begin
            if (q.size() == 0) begin
                chk("spurious_out", 64'(out_data), 64'hDEAD_0000_0000);
            end else begin
                e = q.pop_front();
                chk("out_data", 64'(out_data), 64'(e.d));
                chk("out_lane", 64'(out_lane), 64'(e.l));
            end
            last_out = out_data;
        end
        if (acc) begin
            e.d = mix_m(d, keys_m[ln], md);
            e.l = ln;
            q.push_back(e);
        end
        if (we) keys_m[cl] = ck;
`ifdef KEYED_MIX_STATS_EN
        if (stat_exp_vld) chk("stat_count", 64'(stat_count), 64'(stat_exp));
        stat_exp = cnt_m[stat_lane];
        stat_exp_vld = 1'b1;
        if (stat_clr_n) begin
            for (int i = 0; i < LANES; i++) cnt_m[i] = 0;
        end else if (ohs && cnt_m[out_lane] < CMAX) begin
            cnt_m[out_lane]++;
        end
`endif
        prev_stall = out_valid && !ordy;
        prev_data  = out_data;
        prev_lane  = out_lane;
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, '0, '0, 2'd0, ordy, 1'b0, '0, '0, 1'b0);
    endtask

    // Send one word into an idle pipe (optionally with a key write), then
    // wait for it with out_ready high; check latency and value.
    task automatic send_one_w(input string tag, input logic [WIDTH-1:0] d,
                              input logic [LANE_W-1:0] ln, input logic [1:0] md,
                              input logic [WIDTH-1:0] exp, input bit we,
                              input logic [WIDTH-1:0] ck);
        int  n;
        bit  seen;
        step(1'b1, d, ln, md, 1'b1, we, ln, ck, 1'b0);
        chk({tag, "_acc"}, 64'(acc), 64'd1);
        n = 0; seen = 1'b0;
        while (!seen && n < 10) begin
            idle(1'b1);
            n++;
            if (out_valid) seen = 1'b1;
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({tag, "_lat"}, 64'(n), 64'(STAGES));
            chk({tag, "_val"}, 64'(out_data), 64'(exp));
            chk({tag, "_lane"}, 64'(out_lane), 64'(ln));
        end
    endtask

    task automatic send_one(input string tag, input logic [WIDTH-1:0] d,
                            input logic [LANE_W-1:0] ln, input logic [1:0] md,
                            input logic [WIDTH-1:0] exp);
        send_one_w(tag, d, ln, md, exp, 1'b0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() != 0; i++) idle(1'b1);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    logic [WIDTH-1:0] words[8];

    initial begin
        model_reset();
        step(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, '0, '0, 1'b1);
        idle(1'b0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_lane", 64'(out_lane), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Basic modes and latency
        send_one("pass", 32'h1234_5678, 2'd2, 2'd0, 32'h1234_5678);
        send_one("inv", 32'h0000_00FF, 2'd1, 2'd1, 32'hFFFF_FF00);
        send_one("keyed", 32'h0, 2'd0, 2'd2, 32'hFFFF_FFEF);
        send_one("keyrot", 32'h0, 2'd0, 2'd3, 32'hFFFF_FFDF);

        // Key write in the same cycle as a word on that lane
        send_one_w("kw_old", 32'h0, 2'd1, 2'd2, 32'hFFFF_FFEF, 1'b1, 32'hA5A5_A5A5);
        send_one("kw_new", 32'h0, 2'd1, 2'd2, 32'h5A5A_5A5A);

        // 8 words back to back with a 3-cycle downstream stall
        for (int i = 0; i < 8; i++) words[i] = $urandom;
        begin
            int idx, c;
            idx = 0; c = 0;
            while (idx < 8 && c < 40) begin
                step(1'b1, words[idx], 2'(idx), 2'(idx), !(c >= 3 && c <= 5),
                     1'b0, '0, '0, 1'b0);
                if (c >= 3 && c <= 5) chk("stall_in_ready", 64'(in_ready), 64'd0);
                if (acc) idx++;
                c++;
            end
            chk("b2b_all_sent", 64'(idx), 64'd8);
        end
        drain();

        // Reset with two words in flight
        step(1'b1, 32'h1111_1111, 2'd3, 2'd0, 1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 32'h2222_2222, 2'd3, 2'd0, 1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, '0, '0, 1'b1);
        idle(1'b1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        send_one("midrst_key", 32'h0, 2'd1, 2'd2, 32'hFFFF_FFEF);

`ifdef KEYED_MIX_STATS_EN
        stat_clr_n = 1'b1; idle(1'b1); stat_clr_n = 1'b0;
        for (int i = 0; i < 5; i++) send_one("st_w", 32'(i), 2'd3, 2'd0, 32'(i));
        stat_lane_n = 2'd3;
        idle(1'b1); idle(1'b1);
        chk("stat5", 64'(stat_count), (CMAX < 5) ? 64'(CMAX) : 64'd5);
        step(1'b1, 32'h77, 2'd3, 2'd0, 1'b1, 1'b0, '0, '0, 1'b0);
        idle(1'b1);
        stat_clr_n = 1'b1; idle(1'b1); stat_clr_n = 1'b0;
        chk("stat_clr_hs", 64'(ohs), 64'd1);
        idle(1'b1); idle(1'b1);
        chk("stat_clr", 64'(stat_count), 64'd0);
`endif

        // Random traffic with random backpressure and key writes
        for (int i = 0; i < 400; i++) begin
`ifdef KEYED_MIX_STATS_EN
            stat_lane_n = 2'($urandom);
            stat_clr_n  = ($urandom_range(0, 49) == 0);
`endif
            step($urandom_range(0, 3) != 0, $urandom, 2'($urandom), 2'($urandom),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                 2'($urandom), $urandom, 1'b0);
        end
`ifdef KEYED_MIX_STATS_EN
        stat_clr_n = 1'b0;
`endif
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
